// File: rtl/byte_serializer_pkg.sv
// Shared definitions for the byte serializer: state encodings and a
// constant width helper used to size the bit counter.
package byte_serializer_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  typedef enum logic {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT
  } state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width_v;
    width_v = 32'd0;
    for (int unsigned i = 32'd0; i < 32'd32; i++) begin
      if ((64'd1 << i) < 64'(value)) width_v = i + 32'd1;
    end
    return width_v;
  endfunction

endpackage

// File: rtl/byte_serializer_bit_down_counter.sv
// Loadable down-counter with enable; saturates at zero and flags it.
module bit_down_counter #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_value,
  output logic             zero
);

  logic [CNT_W-1:0] count_r;

  // Count register: load has priority over decrement, never wraps below zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_value;
    end else if (en && (count_r != '0)) begin
      count_r <= count_r - CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == '0);

endmodule

// File: rtl/byte_serializer.sv
// Parallel-in, serial-out converter: takes a word on a valid/ready load
// handshake and streams it one bit per accepted beat, flagging the last bit.
module byte_serializer
  import byte_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_out,
  output logic             ser_last,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = clog2(WIDTH);

  state_e           state_r;
  logic [WIDTH-1:0] shreg_r;
  logic             done_r;
  logic             load_s;
  logic             beat_s;
  logic             cnt_zero_s;

  assign load_s = (state_r == IDLE) && load_valid;
  assign beat_s = (state_r == SHIFT) && ser_ready;

  bit_down_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load       (load_s),
    .en         (beat_s),
    .load_value (CNT_W'(WIDTH - 1)),
    .zero       (cnt_zero_s)
  );

  // Control FSM and shift register; the register is cleared on the final beat
  // so the serial line idles low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      shreg_r <= '0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (load_valid) begin
            shreg_r <= data_in;
            state_r <= SHIFT;
          end
        end
        SHIFT: begin
          if (ser_ready) begin
            if (cnt_zero_s) begin
              state_r <= IDLE;
              shreg_r <= '0;
              done_r  <= 1'b1;
            end else if (MSB_FIRST) begin
              shreg_r <= {shreg_r[WIDTH-2:0], 1'b0};
            end else begin
              shreg_r <= {1'b0, shreg_r[WIDTH-1:1]};
            end
          end
        end
        default: begin
          state_r <= IDLE;
          shreg_r <= '0;
        end
      endcase
    end
  end

  assign load_ready = (state_r == IDLE);
  assign ser_valid  = (state_r == SHIFT);
  assign busy       = (state_r == SHIFT);
  assign ser_out    = MSB_FIRST ? shreg_r[WIDTH-1] : shreg_r[0];
  assign ser_last   = (state_r == SHIFT) && cnt_zero_s;
  assign done       = done_r;

endmodule
